// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
// Shared definitions for the operand fetch stage and the write-back stage:
// register file geometry, write-back control encodings and a popcount helper.
package operand_fetch_pkg;

    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        WB_NONE   = 2'b00,
        WB_LOAD   = 2'b01,
        WB_RESULT = 2'b10,
        WB_RSVD   = 2'b11
    } wb_ctrl_e;

    // Number of set bits in a per-register flag vector.
    function automatic logic [ADDR_WIDTH:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [ADDR_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard
// One pending bit per architectural register marking an in-flight writer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rs_a, rs_b          source addresses checked for RAW hazards
//   rd, rd_write        destination checked for WAW and marked on accept
//   wb_en, wb_addr      qualified write-back; clears the pending bit
//   set_en              instruction accepted this cycle
//   ready               no RAW/WAW hazard (combinational)
//   pending_count       registered number of pending registers
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs_a,
    input  logic [ADDR_WIDTH-1:0] rs_b,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  rd_write,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  set_en,
    output logic                  ready,
    output logic [ADDR_WIDTH:0]   pending_count
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                raw_a;
    logic                raw_b;
    logic                waw;

    // A write-back landing this cycle resolves the hazard on its register.
    always_comb begin
        raw_a = (rs_a != '0) && pending_q[rs_a] && !(wb_en && (wb_addr == rs_a));
        raw_b = (rs_b != '0) && pending_q[rs_b] && !(wb_en && (wb_addr == rs_b));
        waw   = rd_write && (rd != '0) && pending_q[rd] && !(wb_en && (wb_addr == rd));
        ready = !raw_a && !raw_b && !waw;
    end

    // Set is applied after clear so a new writer keeps ownership of the register.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (set_en && rd_write && (rd != '0)) begin
            pending_d[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            pending_count <= '0;
        end else begin
            pending_q     <= pending_d;
            pending_count <= popcount(pending_d);
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
// Register-file read stage. Holds the architectural registers, consumes the
// write-back port, and issues operand pairs only when the scoreboard reports
// no hazard. Write-back data is bypassed into same-cycle reads.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   issueValid, rsA, rsB, rd,       instruction from decode
//   rdWrite
//   issueReady                      combinational accept condition
//   writeBackControl, wbAddr,       write-back port
//   writeData
//   operandValid, operandA,         registered operands to execute
//   operandB, operandRd,
//   operandRdWrite
//   pendingCount                    registered count of in-flight writers
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] rsA,
    input  logic [ADDR_WIDTH-1:0] rsB,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  rdWrite,
    output logic                  issueReady,
    input  logic [1:0]            writeBackControl,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  operandValid,
    output logic [DATA_WIDTH-1:0] operandA,
    output logic [DATA_WIDTH-1:0] operandB,
    output logic [ADDR_WIDTH-1:0] operandRd,
    output logic                  operandRdWrite,
    output logic [ADDR_WIDTH:0]   pendingCount
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wb_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;

    // Reserved encoding neither writes nor clears pending; r0 is never written.
    assign wb_en  = ((writeBackControl == WB_LOAD) || (writeBackControl == WB_RESULT))
                    && (wbAddr != '0);
    assign accept = issueValid && issueReady;

    operand_fetch_scoreboard u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_a          (rsA),
        .rs_b          (rsB),
        .rd            (rd),
        .rd_write      (rdWrite),
        .wb_en         (wb_en),
        .wb_addr       (wbAddr),
        .set_en        (accept),
        .ready         (issueReady),
        .pending_count (pendingCount)
    );

    // Source 0 reads zero; otherwise same-cycle write-back beats the array.
    always_comb begin
        if (rsA == '0) begin
            src_a = '0;
        end else if (wb_en && (wbAddr == rsA)) begin
            src_a = writeData;
        end else begin
            src_a = regs_q[rsA];
        end
        if (rsB == '0) begin
            src_b = '0;
        end else if (wb_en && (wbAddr == rsB)) begin
            src_b = writeData;
        end else begin
            src_b = regs_q[rsB];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wbAddr] <= writeData;
        end
    end

    // Operand fields hold through bubbles; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operandValid   <= 1'b0;
            operandA       <= '0;
            operandB       <= '0;
            operandRd      <= '0;
            operandRdWrite <= 1'b0;
        end else begin
            operandValid <= accept;
            if (accept) begin
                operandA       <= src_a;
                operandB       <= src_b;
                operandRd      <= rd;
                operandRdWrite <= rdWrite;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
// Drives directed and random traffic into operand_fetch and compares every
// output against a behavioural register-file/pending-set model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issueValid;
    logic [3:0]  rsA, rsB, rd;
    logic        rdWrite;
    logic        issueReady;
    logic [1:0]  writeBackControl;
    logic [3:0]  wbAddr;
    logic [31:0] writeData;
    logic        operandValid;
    logic [31:0] operandA, operandB;
    logic [3:0]  operandRd;
    logic        operandRdWrite;
    logic [4:0]  pendingCount;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issueValid       (issueValid),
        .rsA              (rsA),
        .rsB              (rsB),
        .rd               (rd),
        .rdWrite          (rdWrite),
        .issueReady       (issueReady),
        .writeBackControl (writeBackControl),
        .wbAddr           (wbAddr),
        .writeData        (writeData),
        .operandValid     (operandValid),
        .operandA         (operandA),
        .operandB         (operandB),
        .operandRd        (operandRd),
        .operandRdWrite   (operandRdWrite),
        .pendingCount     (pendingCount)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state: register values, set of in-flight destinations, outputs.
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    logic        m_valid, m_rdw;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_rd;
    logic        obs_ready;

    function automatic logic [31:0] m_read(input logic [3:0] s, input bit wb,
                                           input logic [3:0] wa, input logic [31:0] wd);
        if (s == 0) return 32'd0;
        if (wb && wa == s) return wd;
        return m_regs[s];
    endfunction

    function automatic bit m_blocked(input logic [3:0] r, input bit wb, input logic [3:0] wa);
        return (r != 0) && m_pend[r] && !(wb && wa == r);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_a     = 32'd0;
        m_b     = 32'd0;
        m_rd    = 4'd0;
        m_rdw   = 1'b0;
    endtask

    // One clock: drive, check issueReady, clock, update model, check outputs.
    task automatic cycle(input bit rst, input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input bit rw, input logic [1:0] wbc,
                         input logic [3:0] wa, input logic [31:0] wd);
        bit wb, exp_ready, acc;
        rst_n = ~rst; issueValid = v; rsA = a; rsB = b; rd = d; rdWrite = rw;
        writeBackControl = wbc; wbAddr = wa; writeData = wd;
        wb = (wbc == 2'b01 || wbc == 2'b10) && wa != 0;
        exp_ready = !m_blocked(a, wb, wa) && !m_blocked(b, wb, wa)
                    && !(rw && m_blocked(d, wb, wa));
        #1;
        obs_ready = issueReady;
        check("issueReady", {31'd0, issueReady}, {31'd0, exp_ready});
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            acc = v && exp_ready;
            m_valid = acc;
            if (acc) begin
                m_a = m_read(a, wb, wa, wd);
                m_b = m_read(b, wb, wa, wd);
                m_rd = d;
                m_rdw = rw;
            end
            if (wb) begin
                m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (acc && rw && d != 0) m_pend[d] = 1'b1;
        end
        #1;
        check("operandValid", {31'd0, operandValid}, {31'd0, m_valid});
        check("operandA", operandA, m_a);
        check("operandB", operandB, m_b);
        check("operandRd", {28'd0, operandRd}, {28'd0, m_rd});
        check("operandRdWrite", {31'd0, operandRdWrite}, {31'd0, m_rdw});
        check("pendingCount", {27'd0, pendingCount}, $countones(m_pend));
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        obs_ready = 1'b0;
        cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        check("reset_count", {27'd0, pendingCount}, 32'd0);
        check("reset_valid", {31'd0, operandValid}, 32'd0);

        // Issue writer of r3 from zero sources.
        cycle(0, 1, 0, 0, 3, 1, 2'b00, 0, 0);
        check("tp1_ready", {31'd0, obs_ready}, 32'd1);
        check("tp1_a", operandA, 32'd0);
        check("tp1_count", {27'd0, pendingCount}, 32'd1);
        // RAW stall on r3, then retry alongside its write-back.
        cycle(0, 1, 3, 0, 0, 0, 2'b00, 0, 0);
        check("tp2_stall", {31'd0, obs_ready}, 32'd0);
        check("tp2_bubble", {31'd0, operandValid}, 32'd0);
        cycle(0, 1, 3, 0, 0, 0, 2'b10, 3, 200);
        check("tp2_bypass", operandA, 32'd200);
        check("tp2_cleared", {27'd0, pendingCount}, 32'd0);
        // Load to r5, read it next cycle.
        cycle(0, 0, 0, 0, 0, 0, 2'b01, 5, 100);
        cycle(0, 1, 0, 5, 0, 0, 2'b00, 0, 0);
        check("tp3_b", operandB, 32'd100);
        // Reserved encoding while r3 pending.
        cycle(0, 1, 0, 0, 3, 1, 2'b00, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 2'b11, 3, 7);
        check("tp4_count", {27'd0, pendingCount}, 32'd1);
        cycle(0, 1, 3, 0, 0, 0, 2'b00, 0, 0);
        check("tp4_still_pending", {31'd0, obs_ready}, 32'd0);
        // WAW resolved by same-cycle write-back; new writer keeps r4.
        cycle(0, 1, 0, 0, 4, 1, 2'b00, 0, 0);
        cycle(0, 1, 0, 0, 4, 1, 2'b10, 4, 9);
        check("tp5_accept", {31'd0, obs_ready}, 32'd1);
        check("tp5_count", {27'd0, pendingCount}, 32'd2);
        // Writes to r0 are dropped.
        cycle(0, 0, 0, 0, 0, 0, 2'b10, 0, 55);
        cycle(0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        check("tp6_r0", operandA, 32'd0);
        // Three pending, then reset; later write-back still lands in the array.
        cycle(0, 1, 0, 0, 6, 1, 2'b00, 0, 0);
        check("tp7_three", {27'd0, pendingCount}, 32'd3);
        cycle(1, 1, 3, 0, 0, 0, 2'b00, 0, 0);
        check("tp7_count", {27'd0, pendingCount}, 32'd0);
        check("tp7_valid", {31'd0, operandValid}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 2'b10, 3, 77);
        cycle(0, 1, 3, 0, 0, 0, 2'b00, 0, 0);
        check("tp7_r3", operandA, 32'd77);

        // Random traffic over a narrow address range so hazards are frequent.
        for (int n = 0; n < 2000; n++) begin
            logic [3:0]  ra, rb, rdd, wa;
            logic [1:0]  wbc;
            logic [31:0] wd;
            ra  = 4'($urandom_range(0, 7));
            rb  = 4'($urandom_range(0, 7));
            rdd = 4'($urandom_range(0, 7));
            wa  = 4'($urandom_range(0, 7));
            wbc = 2'($urandom_range(0, 3));
            wd  = $urandom;
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ra, rb, rdd,
                  $urandom_range(0, 1) == 1, wbc, wa, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
